// File: rtl/tick_monitor.sv
// tick_monitor: measures the spacing of a one-cycle enable strobe against a
// programmed period and tolerance, and tracks lock with a saturating error count.
module tick_monitor #(
    parameter int WIDTH      = 16,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             tick,
    input  logic [WIDTH-1:0] period,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [WIDTH-1:0] last_period,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] LC = GW'(LOCK_COUNT);
    localparam logic [WIDTH+1:0] TOL_X = (WIDTH + 2)'(TOL);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    good_q, good_d;
    logic             to_q, to_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             locked_q;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_count_q;
    logic             err_ev;

    logic [WIDTH+1:0] per_x, hi_x, lo_x, cnt_x;
    logic             in_win, at_tmo;
    logic [WIDTH-1:0] cnt_inc;

    // Window math carries two spare bits so period+TOL+1 never wraps.
    always_comb begin
        per_x   = {2'b00, period};
        cnt_x   = {2'b00, cnt_q};
        hi_x    = per_x + TOL_X;
        lo_x    = (per_x >= TOL_X) ? per_x - TOL_X : '0;
        in_win  = (cnt_x >= lo_x) && (cnt_x <= hi_x);
        at_tmo  = (cnt_x == hi_x + 1'b1);
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        logic bad;
        logic good_ev;
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        to_d    = to_q;
        last_d  = last_q;
        err_ev  = 1'b0;
        bad     = 1'b0;
        good_ev = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            good_d  = '0;
            to_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = FIRST;
                FIRST: begin
                    if (tick) begin
                        cnt_d   = WIDTH'(1);
                        good_d  = '0;
                        state_d = ACQUIRE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (tick) begin
                        cnt_d = WIDTH'(1);
                        // First tick after a timeout only re-arms the counter.
                        if (to_q) begin
                            to_d = 1'b0;
                        end else begin
                            last_d = cnt_q;
                            if (in_win) good_ev = 1'b1;
                            else        bad     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (!to_q && at_tmo) begin
                            to_d = 1'b1;
                            bad  = 1'b1;
                        end
                    end
                    if (good_ev && state_q == ACQUIRE) begin
                        good_d = good_q + 1'b1;
                        if (good_q + 1'b1 == LC) state_d = LOCKED;
                    end
                    if (bad) begin
                        good_d  = '0;
                        state_d = ACQUIRE;
                        err_ev  = (state_q == LOCKED);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            good_q      <= '0;
            to_q        <= 1'b0;
            last_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            to_q        <= to_d;
            last_q      <= last_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_ev;
            if (clear_err) begin
                err_count_q <= '0;
            end else if (err_ev && !(&err_count_q)) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign locked      = locked_q;
    assign err_pulse   = err_pulse_q;
    assign last_period = last_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench for tick_monitor: lock, tolerance, timeout, short interval,
// error saturation with clear, disable and asynchronous reset.
module tb_tick_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        tick;
    logic [15:0] period;
    logic        clear_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] last_period;
    logic [1:0]  err_count;

    int errors = 0;
    int checks = 0;

    tick_monitor #(
        .WIDTH(16),
        .TOL(1),
        .LOCK_COUNT(4),
        .ERR_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .tick(tick),
        .period(period),
        .clear_err(clear_err),
        .locked(locked),
        .err_pulse(err_pulse),
        .last_period(last_period),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Produces a tick n cycles after the previous one.
    task automatic interval(input int n);
        tick = 1'b0;
        repeat (n - 1) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        tick      = 1'b0;
        period    = 16'd8;
        clear_err = 1'b0;
        #12;
        chk("rst_locked", locked, 0);
        chk("rst_errp", err_pulse, 0);
        chk("rst_last", last_period, 0);
        chk("rst_errc", err_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Lock acquisition
        en = 1'b1;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (3) interval(8);
        chk("lock_early", locked, 0);
        interval(8);
        chk("lock_up", locked, 1);
        chk("lock_last", last_period, 8);
        chk("lock_errc", err_count, 0);

        // Tolerance edges while locked
        interval(7);
        chk("tol7_last", last_period, 7);
        chk("tol7_lock", locked, 1);
        interval(9);
        chk("tol9_last", last_period, 9);
        interval(8);
        interval(7);
        chk("tol_lock", locked, 1);
        interval(10);
        chk("tol10_lock", locked, 0);
        chk("tol10_errp", err_pulse, 1);
        chk("tol10_errc", err_count, 1);
        chk("tol10_last", last_period, 10);
        tick = 1'b0;
        step();
        chk("errp_one", err_pulse, 0);
        repeat (6) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("relock_last", last_period, 8);
        interval(9);
        interval(7);
        chk("relock_early", locked, 0);
        interval(8);
        chk("relock_up", locked, 1);

        // Missing tick while locked
        tick = 1'b0;
        repeat (9) step();
        chk("tmo_pre_errp", err_pulse, 0);
        chk("tmo_pre_lock", locked, 1);
        step();
        chk("tmo_errp", err_pulse, 1);
        chk("tmo_lock", locked, 0);
        chk("tmo_errc", err_count, 2);
        repeat (15) step();
        chk("tmo_once_errp", err_pulse, 0);
        chk("tmo_once_errc", err_count, 2);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("tmo_resume_last", last_period, 8);
        chk("tmo_resume_errp", err_pulse, 0);
        interval(8);
        interval(9);
        interval(7);
        chk("tmo_relock_early", locked, 0);
        interval(8);
        chk("tmo_relock", locked, 1);

        // Disable while locked, then short interval in ACQUIRE
        en = 1'b0;
        step();
        chk("dis_lock", locked, 0);
        chk("dis_errc", err_count, 2);
        chk("dis_last", last_period, 8);
        en = 1'b1;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        interval(8);
        interval(8);
        interval(3);
        chk("short_errp", err_pulse, 0);
        chk("short_errc", err_count, 2);
        chk("short_last", last_period, 3);
        repeat (3) interval(8);
        chk("short_early", locked, 0);
        interval(8);
        chk("short_lock", locked, 1);

        // Saturation and clear
        for (int i = 0; i < 2; i++) begin
            interval(3);
            chk("sat_errp", err_pulse, 1);
            chk("sat_errc", err_count, 3);
            repeat (4) interval(8);
        end
        chk("sat_lock", locked, 1);
        tick = 1'b0;
        repeat (2) step();
        tick      = 1'b1;
        clear_err = 1'b1;
        step();
        tick      = 1'b0;
        clear_err = 1'b0;
        chk("clr_errc", err_count, 0);
        chk("clr_errp", err_pulse, 1);
        chk("clr_lock", locked, 0);

        // Asynchronous reset mid-interval
        repeat (4) interval(8);
        interval(5);
        chk("pre_rst_errc", err_count, 1);
        repeat (4) interval(8);
        chk("pre_rst_lock", locked, 1);
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_lock", locked, 0);
        chk("arst_errp", err_pulse, 0);
        chk("arst_last", last_period, 0);
        chk("arst_errc", err_count, 0);
        #2;
        reset = 1'b1;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("post_rst_first", last_period, 0);
        interval(8);
        chk("post_rst_cmp", last_period, 8);
        chk("post_rst_lock", locked, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
